cache_mem_arbiter: RTL and testbench



---
 rtl/cache_mem_pkg.sv | 30 +++
 rtl/burst_counter.sv | 32 +++
 rtl/cache_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache-to-memory arbiter.
//   state_t : arbiter FSM states
//   gnt_t   : identity of the granted cache
//   offset_w: word-offset width for a given line length
package cache_mem_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned LINE_WORDS_DEF = 8;
  localparam int unsigned BYTE_OFF       = 2;

  function automatic int unsigned offset_w(input int unsigned words);
    return $clog2(words);
  endfunction

  localparam int unsigned OFFSET_W = offset_w(LINE_WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_BURST = 2'd1,
    DC_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } gnt_t;

endpackage

// File: rtl/burst_counter.sv
// Beat counter for one line burst.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : clear the counter to beat 0 (priority over en)
//   en         : advance one beat; wraps to 0 after the last beat
//   idx        : current beat index
//   last_c     : current beat is the final beat of the line
module burst_counter
  import cache_mem_pkg::*;
#(
  parameter int unsigned WORDS = LINE_WORDS_DEF,
  parameter int unsigned W     = OFFSET_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         last_c
);

  // WORDS is a power of two, so natural overflow gives the wrap to 0
  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + W'(1);
    end
  end

  assign last_c = (idx == W'(WORDS - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between ICache refills and DCache refills/write-backs.
//   ic_req/ic_addr             : ICache refill request, held until ic_done
//   ic_rvalid/ic_rdata/ic_done : ICache refill words and completion pulse
//   dc_req/dc_we/dc_addr       : DCache request (we=1 write-back), held until dc_done
//   dc_wdata/dc_widx           : write-back word for the beat index on dc_widx
//   dc_rvalid/dc_rdata/dc_done : DCache refill words and completion pulse
//   mem_*                      : beat-level memory port (beat done on req & ready)
//   busy                       : arbiter not idle
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ic_req,
  input  logic [ADDR_W-1:0]             ic_addr,
  output logic                          ic_rvalid,
  output logic [DATA_W-1:0]             ic_rdata,
  output logic                          ic_done,
  input  logic                          dc_req,
  input  logic                          dc_we,
  input  logic [ADDR_W-1:0]             dc_addr,
  input  logic [DATA_W-1:0]             dc_wdata,
  output logic [$clog2(LINE_WORDS)-1:0] dc_widx,
  output logic                          dc_rvalid,
  output logic [DATA_W-1:0]             dc_rdata,
  output logic                          dc_done,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int unsigned OFF_W = offset_w(LINE_WORDS);
  localparam int unsigned LOW_W = OFF_W + BYTE_OFF;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LOW_W) - 1);

  state_t            state;
  state_t            state_nxt;
  gnt_t              last_gnt;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic              ic_mask;
  logic              dc_mask;
  logic [OFF_W-1:0]  beat;
  logic              last_c;
  logic              cnt_load;
  logic              cnt_en;
  logic              grant_ic;
  logic              grant_dc;
  logic              ic_beat;
  logic              dc_beat;

  burst_counter #(
    .WORDS (LINE_WORDS),
    .W     (OFF_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .en     (cnt_en),
    .idx    (beat),
    .last_c (last_c)
  );

  // Round-robin pick; a side that was just served is masked for one IDLE
  // cycle because its req is still visible the cycle after its done pulse.
  always_comb begin
    grant_ic = ic_req & ~ic_mask &
               (~(dc_req & ~dc_mask) | (last_gnt == GNT_DC));
    grant_dc = dc_req & ~dc_mask & ~grant_ic;
  end

  assign ic_beat = (state == IC_BURST) & mem_ready;
  assign dc_beat = (state == DC_BURST) & mem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_ic) begin
          state_nxt = IC_BURST;
        end else if (grant_dc) begin
          state_nxt = DC_BURST;
        end
      end
      IC_BURST, DC_BURST: begin
        if (mem_ready && last_c) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-port and counter control decoded from the current state
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      IDLE: cnt_load = 1'b1;
      IC_BURST: begin
        mem_req  = 1'b1;
        mem_addr = base_q + (ADDR_W'(beat) << BYTE_OFF);
        cnt_en   = mem_ready;
        busy     = 1'b1;
      end
      DC_BURST: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_q + (ADDR_W'(beat) << BYTE_OFF);
        mem_wdata = we_q ? dc_wdata : '0;
        cnt_en    = mem_ready;
        busy      = 1'b1;
      end
      DONE:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign dc_widx = beat;

  // Grant bookkeeping: line base, direction and round-robin history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= GNT_IC;
      we_q     <= 1'b0;
      base_q   <= '0;
    end else if ((state == IDLE) && (grant_ic || grant_dc)) begin
      last_gnt <= grant_dc ? GNT_DC : GNT_IC;
      we_q     <= grant_dc & dc_we;
      base_q   <= (grant_dc ? dc_addr : ic_addr) & LINE_MASK;
    end
  end

  // Registered read return, done pulses and the post-done mask
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ic_rvalid <= 1'b0;
      ic_rdata  <= '0;
      ic_done   <= 1'b0;
      dc_rvalid <= 1'b0;
      dc_rdata  <= '0;
      dc_done   <= 1'b0;
      ic_mask   <= 1'b0;
      dc_mask   <= 1'b0;
    end else begin
      ic_rvalid <= ic_beat;
      dc_rvalid <= dc_beat & ~we_q;
      if (ic_beat) begin
        ic_rdata <= mem_rdata;
      end
      if (dc_beat && !we_q) begin
        dc_rdata <= mem_rdata;
      end
      ic_done <= ic_beat & last_c;
      dc_done <= dc_beat & last_c;
      ic_mask <= ic_done;
      dc_mask <= dc_done;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_rvalid;
  logic [31:0] ic_rdata;
  logic        ic_done;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [2:0]  dc_widx;
  logic        dc_rvalid;
  logic [31:0] dc_rdata;
  logic        dc_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  cache_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_rvalid (ic_rvalid),
    .ic_rdata  (ic_rdata),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_widx   (dc_widx),
    .dc_rvalid (dc_rvalid),
    .dc_rdata  (dc_rdata),
    .dc_done   (dc_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns its address as data; the DCache supplies 0xA0 + index
  always_comb begin
    mem_rdata = mem_addr;
    dc_wdata  = 32'hA0 + 32'(dc_widx);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ic_req;
    logic        dc_req;
    logic        dc_we;
    logic        mem_ready;
    logic [31:0] ic_addr;
    logic [31:0] dc_addr;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_ic_rvalid;
    logic [31:0] e_ic_rdata;
    logic        e_ic_done;
    logic        e_dc_rvalid;
    logic        e_dc_done;
    logic        e_busy;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic vec_t idle_row(input logic icr, input logic dcr, input logic we,
                                    input logic [31:0] ia, input logic [31:0] da);
    vec_t v;
    v = '{default: '0};
    v.ic_req    = icr;
    v.dc_req    = dcr;
    v.dc_we     = we;
    v.ic_addr   = ia;
    v.dc_addr   = da;
    v.mem_ready = 1'b1;
    return v;
  endfunction

  // Drive one row's inputs, check its expected outputs, advance one cycle
  task automatic apply(input vec_t v, input string tag, input int c);
    ic_req    = v.ic_req;
    dc_req    = v.dc_req;
    dc_we     = v.dc_we;
    mem_ready = v.mem_ready;
    ic_addr   = v.ic_addr;
    dc_addr   = v.dc_addr;
    #1;
    chk($sformatf("%s c%0d mem_req", tag, c), 32'(mem_req), 32'(v.e_mem_req));
    chk($sformatf("%s c%0d mem_we", tag, c), 32'(mem_we), 32'(v.e_mem_we));
    chk($sformatf("%s c%0d mem_addr", tag, c), mem_addr, v.e_mem_addr);
    chk($sformatf("%s c%0d mem_wdata", tag, c), mem_wdata, v.e_mem_wdata);
    chk($sformatf("%s c%0d ic_rvalid", tag, c), 32'(ic_rvalid), 32'(v.e_ic_rvalid));
    if (v.e_ic_rvalid) chk($sformatf("%s c%0d ic_rdata", tag, c), ic_rdata, v.e_ic_rdata);
    chk($sformatf("%s c%0d ic_done", tag, c), 32'(ic_done), 32'(v.e_ic_done));
    chk($sformatf("%s c%0d dc_rvalid", tag, c), 32'(dc_rvalid), 32'(v.e_dc_rvalid));
    chk($sformatf("%s c%0d dc_done", tag, c), 32'(dc_done), 32'(v.e_dc_done));
    chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(v.e_busy));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ic_req = 1'b0;
    dc_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Caches that hold req until they see their done pulse, dropping it in the
  // next cycle. Checks the first granted line, the second (if two requesters),
  // the idle gap between bursts and the total number of beat cycles.
  task automatic run_seq(input logic ic_on, input logic dc_on, input logic [31:0] ia,
                         input logic [31:0] da, input logic [31:0] first_a,
                         input logic [31:0] second_a, input string tag);
    logic ic_pend;
    logic dc_pend;
    int   beats;
    ic_pend = ic_on;
    dc_pend = dc_on;
    beats   = 0;
    ic_addr = ia;
    dc_addr = da;
    dc_we   = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      ic_req = ic_pend;
      dc_req = dc_pend;
      #1;
      if (mem_req) beats++;
      if (c == 1) chk($sformatf("%s first addr", tag), mem_addr, first_a);
      if (c == 1) chk($sformatf("%s first mem_we", tag), 32'(mem_we), 32'd0);
      if (c == 10) chk($sformatf("%s gap mem_req", tag), 32'(mem_req), 32'd0);
      if (c == 11 && ic_on && dc_on)
        chk($sformatf("%s second addr", tag), mem_addr, second_a);
      if (ic_done) ic_pend = 1'b0;
      if (dc_done) dc_pend = 1'b0;
      @(posedge clk);
      #1;
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    chk($sformatf("%s beats", tag), 32'(beats), (ic_on && dc_on) ? 32'd16 : 32'd8);
    chk($sformatf("%s all served", tag), 32'({ic_pend, dc_pend}), 32'd0);
  endtask

  int beat_of[11];

  initial begin
    rst_n = 1'b0;
    ic_req = 1'b0;
    dc_req = 1'b0;
    dc_we = 1'b0;
    ic_addr = '0;
    dc_addr = '0;
    mem_ready = 1'b1;

    // ICache refill of line 0x1220 (request address has a nonzero offset)
    for (int c = 0; c < 12; c++) begin
      tbl[c] = idle_row(c <= 9, 1'b0, 1'b0, 32'h0000_1234, 32'h0);
      if (c >= 1 && c <= 8) begin
        tbl[c].e_mem_req  = 1'b1;
        tbl[c].e_mem_addr = 32'h1220 + 32'(4 * (c - 1));
        tbl[c].e_busy     = 1'b1;
      end
      if (c >= 2 && c <= 9) begin
        tbl[c].e_ic_rvalid = 1'b1;
        tbl[c].e_ic_rdata  = 32'h1220 + 32'(4 * (c - 2));
      end
      if (c == 9) begin
        tbl[c].e_ic_done = 1'b1;
        tbl[c].e_busy    = 1'b1;
      end
    end
    // DCache write-back of line 0x80; req held one extra cycle after done
    for (int c = 0; c < 14; c++) begin
      tbl[12 + c] = idle_row(1'b0, c <= 10, 1'b1, 32'h0, 32'h0000_0080);
      if (c >= 1 && c <= 8) begin
        tbl[12 + c].e_mem_req   = 1'b1;
        tbl[12 + c].e_mem_we    = 1'b1;
        tbl[12 + c].e_mem_addr  = 32'h80 + 32'(4 * (c - 1));
        tbl[12 + c].e_mem_wdata = 32'hA0 + 32'(c - 1);
        tbl[12 + c].e_busy      = 1'b1;
      end
      if (c == 9) begin
        tbl[12 + c].e_dc_done = 1'b1;
        tbl[12 + c].e_busy    = 1'b1;
      end
    end

    // Reset state
    repeat (3) tick();
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset dc_widx", 32'(dc_widx), 32'd0);
    chk("reset outs", 32'({ic_rvalid, ic_done, dc_rvalid, dc_done, mem_we, busy}), 32'd0);
    chk("reset rdata", ic_rdata | dc_rdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) apply(tbl[i], "icrefill", i);
    for (int i = 12; i < 26; i++) apply(tbl[i], "dcwb", i - 12);

    // Refill with wait states on beat indices 3 and 5
    beat_of = '{0, 0, 1, 2, 3, 3, 4, 5, 5, 6, 7};
    begin
      int rv_cnt;
      rv_cnt = 0;
      ic_addr = 32'h0000_2004;
      for (int c = 0; c < 13; c++) begin
        ic_req    = (c <= 11);
        mem_ready = !(c == 4 || c == 7);
        #1;
        if (c >= 1 && c <= 10) begin
          chk($sformatf("wait c%0d mem_req", c), 32'(mem_req), 32'd1);
          chk($sformatf("wait c%0d mem_addr", c), mem_addr, 32'h2000 + 32'(4 * beat_of[c]));
        end
        chk($sformatf("wait c%0d ic_rvalid", c), 32'(ic_rvalid),
            32'(c == 2 || c == 3 || c == 4 || c == 6 || c == 7 || c == 9 || c == 10 || c == 11));
        if (ic_rvalid) begin
          rv_cnt++;
          chk($sformatf("wait c%0d ic_rdata", c), ic_rdata, 32'h2000 + 32'(4 * beat_of[c - 1]));
        end
        chk($sformatf("wait c%0d ic_done", c), 32'(ic_done), 32'(c == 11));
        @(posedge clk);
        #1;
      end
      chk("wait rvalid count", 32'(rv_cnt), 32'd8);
      ic_req = 1'b0;
      mem_ready = 1'b1;
    end

    // Round-robin: fresh reset so DCache wins the first tie
    do_reset();
    run_seq(1'b1, 1'b1, 32'h400, 32'h300, 32'h300, 32'h400, "tie1");
    run_seq(1'b0, 1'b1, 32'h0, 32'h500, 32'h500, 32'h0, "dconly");
    run_seq(1'b1, 1'b1, 32'h600, 32'h700, 32'h600, 32'h700, "tie2");

    // Reset in cycle 4 of a DCache refill
    dc_we = 1'b0;
    dc_addr = 32'h900;
    for (int c = 0; c < 10; c++) begin
      dc_req = (c <= 4);
      if (c == 5) rst_n = 1'b1;
      #1;
      if (c == 3) chk("rstmid c3 mem_req", 32'(mem_req), 32'd1);
      if (c == 5) begin
        chk("rstmid c5 mem_req", 32'(mem_req), 32'd0);
        chk("rstmid c5 busy", 32'(busy), 32'd0);
      end
      if (c >= 5) chk($sformatf("rstmid c%0d dc_done", c), 32'(dc_done), 32'd0);
      if (c == 4) rst_n = 1'b0;
      @(posedge clk);
      #1;
    end
    run_seq(1'b1, 1'b0, 32'hA00, 32'h0, 32'hA00, 32'h0, "afterrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
